// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB write-back register file with GPRs and HI/LO.
// Optional same-cycle write-to-read bypass: define WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_whilo,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

`ifdef WB_REGFILE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] gpr [NREGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Entry 0 is only ever cleared; reads of address 0 are forced to 0 anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        gpr[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (wb_wreg && (wb_wd != '0)) begin
        gpr[wb_wd] <= wb_wdata;
      end
      if (wb_whilo) begin
        hi_q <= wb_hi;
        lo_q <= wb_lo;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              re,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (rst || !re || (addr == '0)) begin
      val = '0;
    end else if (BYPASS && wb_wreg && (addr == wb_wd)) begin
      val = wb_wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  always_comb begin
    rdata1 = read_port(re1, raddr1, gpr[raddr1]);
    rdata2 = read_port(re2, raddr2, gpr[raddr2]);
  end

  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst) begin
      hi_o = '0;
      lo_o = '0;
    end else if (BYPASS && wb_whilo) begin
      hi_o = wb_hi;
      lo_o = wb_lo;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile with a behavioural model.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (rst || !re || a == 5'd0) return 32'h0;
    if (BYP && wb_wreg && a == wb_wd) return wb_wdata;
    return m_gpr[a];
  endfunction

  // Checks the combinational outputs mid-cycle, then commits the edge to the model.
  task automatic cycle(input string tag);
    #2;
    chk({tag, ":rdata1"}, rdata1, exp_rd(re1, raddr1));
    chk({tag, ":rdata2"}, rdata2, exp_rd(re2, raddr2));
    chk({tag, ":hi_o"}, hi_o, rst ? 32'h0 : (BYP && wb_whilo) ? wb_hi : m_hi);
    chk({tag, ":lo_o"}, lo_o, rst ? 32'h0 : (BYP && wb_whilo) ? wb_lo : m_lo);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else begin
      if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
      if (wb_whilo) begin
        m_hi = wb_hi;
        m_lo = wb_lo;
      end
    end
    #1;
  endtask

  task automatic idle();
    wb_wreg = 1'b0; wb_whilo = 1'b0; wb_wd = 5'd0;
    wb_wdata = 32'h0; wb_hi = 32'h0; wb_lo = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    idle();
    rst = 1'b1; re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd3; raddr2 = 5'd9;
    wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'hFFFF0000; wb_whilo = 1'b1;
    wb_hi = 32'h1234; wb_lo = 32'h5678;
    cycle("reset0");
    cycle("reset1");

    rst = 1'b0;
    idle();
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #2;
      chk("reset_rd1", rdata1, 32'h0);
      chk("reset_rd2", rdata2, 32'h0);
    end
    chk("reset_hi", hi_o, 32'h0);
    chk("reset_lo", lo_o, 32'h0);

    wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEADBEEF;
    raddr1 = 5'd1; raddr2 = 5'd2;
    cycle("wr_r5");
    idle();
    raddr1 = 5'd5; raddr2 = 5'd5;
    cycle("rd_r5");
    #2;
    chk("rd_r5_const", rdata2, 32'hDEADBEEF);
    re1 = 1'b0;
    cycle("rd_r5_re0");
    re1 = 1'b1;

    wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'h12345678; raddr1 = 5'd0;
    cycle("wr_r0");
    idle();
    cycle("rd_r0");

    wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'hA5A5A5A5;
    raddr1 = 5'd7; raddr2 = 5'd7;
    #2;
    chk("byp_r7", rdata1, BYP ? 32'hA5A5A5A5 : 32'h0);
    cycle("byp_r7");
    idle();
    #2;
    chk("after_r7", rdata1, 32'hA5A5A5A5);
    cycle("after_r7");

    wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'hFFFFFFFF;
    wb_wreg = 1'b1; wb_wd = 5'd31; wb_wdata = 32'h55;
    raddr1 = 5'd31;
    cycle("hilo_wr");
    idle();
    #2;
    chk("hilo_hi", hi_o, 32'h1);
    chk("hilo_lo", lo_o, 32'hFFFFFFFF);
    chk("hilo_r31", rdata1, 32'h55);
    cycle("hilo_rd");

    rst = 1'b1; wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h77;
    wb_whilo = 1'b1; wb_hi = 32'h9; wb_lo = 32'h9; raddr1 = 5'd3;
    cycle("rst_mid");
    rst = 1'b0;
    idle();
    raddr1 = 5'd3; raddr2 = 5'd31;
    #2;
    chk("rst_mid_r3", rdata1, 32'h0);
    chk("rst_mid_hi", hi_o, 32'h0);
    cycle("rst_mid_after");

    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      wb_wreg  = $urandom_range(0, 1);
      wb_wd    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wb_wdata = $urandom;
      wb_whilo = ($urandom_range(0, 3) == 0);
      wb_hi    = $urandom;
      wb_lo    = $urandom;
      re1      = ($urandom_range(0, 7) != 0);
      re2      = ($urandom_range(0, 7) != 0);
      raddr1   = ($urandom_range(0, 1) != 0) ? wb_wd : 5'($urandom);
      raddr2   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
